// File: rtl/div_pkg.sv
// Shared types and constants for the iterative radix-2 divider.
//   div_state_e       : sequencer state encoding (2 bits)
//   DIV_WIDTH         : default operand/result width
//   div_cnt_w()       : iteration counter width for a given operand width
//   DIV_CNT_W         : counter width at the default operand width
//   DIV_ZERO_QUO_FILL : fill bit of the zero-divisor quotient (all ones)
package div_pkg;

  localparam int unsigned DIV_WIDTH = 32;

  // Counter must reach WIDTH itself, hence WIDTH+1 codes.
  function automatic int unsigned div_cnt_w(input int unsigned w);
    return $clog2(w + 1);
  endfunction

  localparam int unsigned DIV_CNT_W = div_cnt_w(DIV_WIDTH);

  // Zero-divisor quotient is this bit replicated across the result width.
  localparam logic DIV_ZERO_QUO_FILL = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_ctrl_if.sv
// Execute-stage divider handshake bundle.
//   master : drives StartDivE, SignedDivE, AnnulE, OpAE, OpBE
//   slave  : drives DivReadyE, BusyE, ResultLO, ResultHI
interface div_ctrl_if #(
  parameter int unsigned WIDTH = div_pkg::DIV_WIDTH
);
  logic             StartDivE;
  logic             SignedDivE;
  logic             AnnulE;
  logic [WIDTH-1:0] OpAE;
  logic [WIDTH-1:0] OpBE;
  logic             DivReadyE;
  logic             BusyE;
  logic [WIDTH-1:0] ResultLO;
  logic [WIDTH-1:0] ResultHI;

  modport master (
    output StartDivE, SignedDivE, AnnulE, OpAE, OpBE,
    input  DivReadyE, BusyE, ResultLO, ResultHI
  );

  modport slave (
    input  StartDivE, SignedDivE, AnnulE, OpAE, OpBE,
    output DivReadyE, BusyE, ResultLO, ResultHI
  );
endinterface

// File: rtl/div_iter_step.sv
// One combinational restoring-division step on magnitudes.
//   rem_i, quo_i  : partial remainder and dividend/quotient shift register
//   divisor_i     : divisor magnitude
//   rem_o, quo_o  : values after shifting {rem,quo} left and trial subtract
module div_iter_step
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  logic           fits;

  // Shifted remainder keeps the bit pushed out of rem, so the subtract
  // needs WIDTH+1 bits to hold the borrow.
  assign shifted = {rem_i, quo_i[WIDTH-1]};
  assign trial   = shifted - {1'b0, divisor_i};
  assign fits    = (shifted >= {1'b0, divisor_i});

  always_comb begin
    rem_o = shifted[WIDTH-1:0];
    quo_o = {quo_i[WIDTH-2:0], 1'b0};
    if (fits) begin
      rem_o = trial[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle sequencer for DIV/DIVU in the execute stage.
//   clk, rst_n : pipeline clock, async active-low reset
//   bus        : div_ctrl_if.slave (start/sign/annul/operands in,
//                ready/busy/quotient(LO)/remainder(HI) out)
// IDLE latches operand magnitudes, RUN does WIDTH restoring steps,
// FIX applies signs and writes results, DONE pulses DivReadyE.
module div_ctrl
  import div_pkg::*;
#(
  parameter int unsigned WIDTH     = DIV_WIDTH,
  parameter bit          ZERO_FAST = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  div_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W = div_cnt_w(WIDTH);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             qsign_q, qsign_d;
  logic             rsign_q, rsign_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;

  logic [WIDTH-1:0] step_rem, step_quo;
  logic             a_neg, b_neg;

  div_iter_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  assign a_neg = bus.SignedDivE & bus.OpAE[WIDTH-1];
  assign b_neg = bus.SignedDivE & bus.OpBE[WIDTH-1];

  // Next-state and datapath updates.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    qsign_d  = qsign_q;
    rsign_d  = rsign_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    unique case (state_q)
      IDLE: begin
        if (bus.StartDivE && !bus.AnnulE) begin
          // Dividend magnitude is loaded into quo; it shifts out as quotient bits shift in.
          quo_d   = a_neg ? (~bus.OpAE) + WIDTH'(1) : bus.OpAE;
          dvs_d   = b_neg ? (~bus.OpBE) + WIDTH'(1) : bus.OpBE;
          rem_d   = '0;
          cnt_d   = '0;
          qsign_d = a_neg ^ b_neg;
          rsign_d = a_neg;
          if (ZERO_FAST && (bus.OpBE == '0)) begin
            res_lo_d = {WIDTH{DIV_ZERO_QUO_FILL}};
            res_hi_d = bus.OpAE;
            state_d  = DONE;
          end else begin
            state_d  = RUN;
          end
        end
      end
      RUN: begin
        if (bus.AnnulE) begin
          state_d = IDLE;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = FIX;
          end
        end
      end
      FIX: begin
        if (bus.AnnulE) begin
          state_d = IDLE;
        end else begin
          res_lo_d = qsign_q ? (~quo_q) + WIDTH'(1) : quo_q;
          res_hi_d = rsign_q ? (~rem_q) + WIDTH'(1) : rem_q;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      qsign_q  <= 1'b0;
      rsign_q  <= 1'b0;
      res_lo_q <= '0;
      res_hi_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      qsign_q  <= qsign_d;
      rsign_q  <= rsign_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
    end
  end

  // Ready and busy decode directly from the state register.
  assign bus.DivReadyE = (state_q == DONE);
  assign bus.BusyE     = (state_q == RUN);
  assign bus.ResultLO  = res_lo_q;
  assign bus.ResultHI  = res_hi_q;

endmodule
